// File: rtl/pfb_input_scheduler.sv
// ---------------------------------------------------------------------------
// pfb_input_scheduler
// Front-end scheduler for the polyphase filter bank. Buffers complex input
// samples in a small FIFO, commutates them onto descending channel indices
// (NUM_CHANNELS-1 down to 0, wrapping), and issues them to pfb_filter with at
// least MIN_ISSUE_INTERVAL cycles between issues. A zero-flush sequence
// issues NUM_CHANNELS*FLUSH_ROUNDS zero samples to clear filter state.
//
// Ports
//   Clk, Rst_n            clock, asynchronous active-low reset
//   Enable                0 = IDLE: input dropped, FIFO cleared, index reset
//   Flush_req             single-cycle flush request (honoured in RUN only)
//   Input_valid/_sync     sample strobe / sample belongs on top channel
//   Input_i, Input_q      signed sample
//   Output_valid          one-cycle issue strobe
//   Output_index          channel of the issued sample
//   Output_i, Output_q    issued sample (zero during flush)
//   Busy                  high while flushing
//   Error_input_overflow  one-cycle pulse when a sample hit a full FIFO
//
// Optional feature macro: PFB_INPUT_SCHEDULER_STATS_EN
//   Adds Stat_issued (32 b, non-flush issues) and Stat_dropped (16 b,
//   saturating overflow count); both cleared by reset and while in IDLE.
// ---------------------------------------------------------------------------
module pfb_input_scheduler #(
   parameter int unsigned NUM_CHANNELS        = 32,
   parameter int unsigned CHANNEL_INDEX_WIDTH = 5,
   parameter int unsigned DATA_WIDTH          = 12,
   parameter int unsigned FIFO_DEPTH          = 16,
   parameter int unsigned MIN_ISSUE_INTERVAL  = 2,
   parameter int unsigned FLUSH_ROUNDS        = 12
) (
   input  logic                                  Clk,
   input  logic                                  Rst_n,
   input  logic                                  Enable,
   input  logic                                  Flush_req,
   input  logic                                  Input_valid,
   input  logic                                  Input_sync,
   input  logic signed [DATA_WIDTH-1:0]          Input_i,
   input  logic signed [DATA_WIDTH-1:0]          Input_q,
   output logic                                  Output_valid,
   output logic        [CHANNEL_INDEX_WIDTH-1:0] Output_index,
   output logic signed [DATA_WIDTH-1:0]          Output_i,
   output logic signed [DATA_WIDTH-1:0]          Output_q,
   output logic                                  Busy,
   output logic                                  Error_input_overflow
`ifdef PFB_INPUT_SCHEDULER_STATS_EN
   ,
   output logic        [31:0]                    Stat_issued,
   output logic        [15:0]                    Stat_dropped
`endif
);

   localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW     = AW + 1;
   localparam int unsigned SPC_W  = (MIN_ISSUE_INTERVAL > 1) ? $clog2(MIN_ISSUE_INTERVAL) : 1;
   localparam int unsigned FL_TOT = NUM_CHANNELS * FLUSH_ROUNDS;
   localparam int unsigned FL_W   = $clog2(FL_TOT + 1);

   localparam logic [CHANNEL_INDEX_WIDTH-1:0] LAST_IDX   = CHANNEL_INDEX_WIDTH'(NUM_CHANNELS - 1);
   localparam logic [SPC_W-1:0]               SPC_LOAD   = SPC_W'(MIN_ISSUE_INTERVAL - 1);
   localparam logic [FL_W-1:0]                FLUSH_LAST = FL_W'(FL_TOT - 1);
   localparam logic [CW-1:0]                  FULL_CNT   = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_e;

   typedef struct packed {
      logic                          sync;
      logic signed [DATA_WIDTH-1:0]  i;
      logic signed [DATA_WIDTH-1:0]  q;
   } entry_t;

   state_e                            state_q, state_d;
   entry_t                            mem_q [FIFO_DEPTH];
   logic [AW-1:0]                     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]                     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]                     count_q, count_d;
   logic [CHANNEL_INDEX_WIDTH-1:0]    idx_q, idx_d;
   logic [SPC_W-1:0]                  spacing_q, spacing_d;
   logic [FL_W-1:0]                   flush_cnt_q, flush_cnt_d;
   logic                              out_valid_q, out_valid_d;
   logic [CHANNEL_INDEX_WIDTH-1:0]    out_index_q, out_index_d;
   logic signed [DATA_WIDTH-1:0]      out_i_q, out_i_d;
   logic signed [DATA_WIDTH-1:0]      out_q_q, out_q_d;
   logic                              busy_q, busy_d;
   logic                              ovf_q, ovf_d;

   logic                              full_c;
   logic                              empty_c;
   logic                              push_c;
   logic                              pop_c;
   logic                              issue_ok_c;
   entry_t                            in_entry_c;
   entry_t                            head_c;
   logic [CHANNEL_INDEX_WIDTH-1:0]    iss_idx_c;

   // Sample storage: write-only port, no reset needed on the data array
   always_ff @(posedge Clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= in_entry_c;
      end
   end

   // State and control registers
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         idx_q       <= LAST_IDX;
         spacing_q   <= '0;
         flush_cnt_q <= '0;
         out_valid_q <= 1'b0;
         out_index_q <= '0;
         out_i_q     <= '0;
         out_q_q     <= '0;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         spacing_q   <= spacing_d;
         flush_cnt_q <= flush_cnt_d;
         out_valid_q <= out_valid_d;
         out_index_q <= out_index_d;
         out_i_q     <= out_i_d;
         out_q_q     <= out_q_d;
         busy_q      <= busy_d;
         ovf_q       <= ovf_d;
      end
   end

   // Next-state, FIFO control, issue and commutation logic
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      idx_d       = idx_q;
      spacing_d   = (spacing_q != '0) ? spacing_q - SPC_W'(1) : spacing_q;
      flush_cnt_d = flush_cnt_q;
      out_valid_d = 1'b0;
      out_index_d = out_index_q;
      out_i_d     = out_i_q;
      out_q_d     = out_q_q;
      ovf_d       = 1'b0;
      push_c      = 1'b0;
      pop_c       = 1'b0;
      full_c      = (count_q == FULL_CNT);
      empty_c     = (count_q == '0);
      issue_ok_c  = (spacing_q == '0);
      in_entry_c  = '{sync: Input_sync, i: Input_i, q: Input_q};
      head_c      = empty_c ? in_entry_c : mem_q[rd_ptr_q];
      iss_idx_c   = head_c.sync ? LAST_IDX : idx_q;

      if (!Enable) begin
         state_d     = S_IDLE;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         idx_d       = LAST_IDX;
         spacing_d   = '0;
         flush_cnt_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_RUN;
            end

            S_RUN, S_FLUSH: begin
               // Overflow is judged on registered occupancy, so a same-cycle
               // pop does not rescue the incoming sample.
               push_c = Input_valid && !full_c;
               ovf_d  = Input_valid && full_c;

               if (state_q == S_RUN) begin
                  if (issue_ok_c && (!empty_c || Input_valid)) begin
                     out_valid_d = 1'b1;
                     out_index_d = iss_idx_c;
                     out_i_d     = head_c.i;
                     out_q_d     = head_c.q;
                     idx_d       = (iss_idx_c == '0) ? LAST_IDX : iss_idx_c - CHANNEL_INDEX_WIDTH'(1);
                     spacing_d   = SPC_LOAD;
                     // Empty FIFO: incoming sample bypasses storage entirely
                     if (empty_c) begin
                        push_c = 1'b0;
                     end else begin
                        pop_c = 1'b1;
                     end
                  end
                  if (Flush_req) begin
                     state_d     = S_FLUSH;
                     idx_d       = LAST_IDX;
                     flush_cnt_d = '0;
                  end
               end else begin
                  // Flush issues zeros and leaves buffered input untouched
                  if (issue_ok_c) begin
                     out_valid_d = 1'b1;
                     out_index_d = idx_q;
                     out_i_d     = '0;
                     out_q_d     = '0;
                     idx_d       = (idx_q == '0) ? LAST_IDX : idx_q - CHANNEL_INDEX_WIDTH'(1);
                     spacing_d   = SPC_LOAD;
                     if (flush_cnt_q == FLUSH_LAST) begin
                        state_d     = S_RUN;
                        flush_cnt_d = '0;
                     end else begin
                        flush_cnt_d = flush_cnt_q + FL_W'(1);
                     end
                  end
               end

               if (push_c) begin
                  wr_ptr_d = wr_ptr_q + AW'(1);
               end
               if (pop_c) begin
                  rd_ptr_d = rd_ptr_q + AW'(1);
               end
               case ({push_c, pop_c})
                  2'b10:   count_d = count_q + CW'(1);
                  2'b01:   count_d = count_q - CW'(1);
                  default: count_d = count_q;
               endcase
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      busy_d = (state_d == S_FLUSH);
   end

   assign Output_valid         = out_valid_q;
   assign Output_index         = out_index_q;
   assign Output_i             = out_i_q;
   assign Output_q             = out_q_q;
   assign Busy                 = busy_q;
   assign Error_input_overflow = ovf_q;

`ifdef PFB_INPUT_SCHEDULER_STATS_EN
   logic [31:0] stat_issued_q, stat_issued_d;
   logic [15:0] stat_dropped_q, stat_dropped_d;

   // Statistics counters: non-flush issues and saturating drop count
   always_comb begin
      stat_issued_d  = stat_issued_q;
      stat_dropped_d = stat_dropped_q;
      if (!Enable) begin
         stat_issued_d  = '0;
         stat_dropped_d = '0;
      end else begin
         if (out_valid_d && (state_q == S_RUN)) begin
            stat_issued_d = stat_issued_q + 32'(1);
         end
         if (ovf_d && (stat_dropped_q != 16'hFFFF)) begin
            stat_dropped_d = stat_dropped_q + 16'(1);
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         stat_issued_q  <= '0;
         stat_dropped_q <= '0;
      end else begin
         stat_issued_q  <= stat_issued_d;
         stat_dropped_q <= stat_dropped_d;
      end
   end

   assign Stat_issued  = stat_issued_q;
   assign Stat_dropped = stat_dropped_q;
`endif

endmodule
